// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin front end for the 1 KB data RAM.
// One single-word access is granted per cycle. Locks are bounded. Bad addresses complete with err.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = 1024,
  parameter int LOCK_MAX  = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,

  output logic              ram_sel,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(LOCK_MAX);

  // Per-port views of the request bundles, indexed by port number.
  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0]        lock;
  logic [1:0]        addr_err;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] addr  [2];
  logic [DATA_W-1:0] wdata [2];

  logic [1:0]        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];

  logic              gnt_any;
  logic              gnt_port;
  logic              grant_ok;
  logic              own_port;
  logic [CNT_W-1:0]  cnt_inc;

  assign req      = {m1_req, m0_req};
  assign we       = {m1_we, m0_we};
  assign lock     = {m1_lock, m0_lock};
  assign addr[0]  = m0_addr;
  assign addr[1]  = m1_addr;
  assign wdata[0] = m0_wdata;
  assign wdata[1] = m1_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi = gi + 1) begin : g_port
      assign addr_err[gi] = (addr[gi][1:0] != 2'b00) || (addr[gi] > LAST_WORD);
      assign rvalid_d[gi] = gnt[gi];
      assign err_d[gi]    = gnt[gi] & addr_err[gi];
      // Only a successful read returns RAM data; writes and errors complete with zero.
      assign rdata_d[gi]  = (gnt[gi] && !we[gi] && !addr_err[gi]) ? ram_rdata : '0;
    end
  endgenerate

  // Owner-only grant while locked; otherwise the port that did not win last time.
  always_comb begin
    gnt = 2'b00;
    if (!reset) begin
      case (state_q)
        ST_OWN0: gnt[0] = req[0];
        ST_OWN1: gnt[1] = req[1];
        default: begin
          if (req == 2'b11) begin
            gnt = last_gnt_q ? 2'b01 : 2'b10;
          end else begin
            gnt = req;
          end
        end
      endcase
    end
  end

  assign gnt_any  = |gnt;
  assign gnt_port = gnt[1];
  assign grant_ok = gnt_any && !addr_err[gnt_port];

  always_comb begin
    state_d    = state_q;
    last_gnt_d = gnt_any ? gnt_port : last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    cnt_inc    = lock_cnt_q + 1'b1;
    own_port   = (state_q == ST_OWN1);
    case (state_q)
      ST_OWN0, ST_OWN1: begin
        // Stay owned only while the owner keeps a locked request under the limit.
        if (req[own_port] && lock[own_port] && (cnt_inc < CNT_LIMIT)) begin
          lock_cnt_d = cnt_inc;
        end else begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
        if (gnt_any && lock[gnt_port] && (LOCK_MAX > 1)) begin
          state_d    = gnt_port ? ST_OWN1 : ST_OWN0;
          lock_cnt_d = CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    ram_sel   = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_ok) begin
      ram_sel   = 1'b1;
      ram_read  = !we[gnt_port];
      ram_write = we[gnt_port];
      ram_addr  = addr[gnt_port];
      ram_wdata = wdata[gnt_port];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      err_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign m0_gnt    = gnt[0];
  assign m1_gnt    = gnt[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for the 1 KB data RAM slave. Port 0 (core load/store unit) and port 1 (DMA/debug master) each issue single-word requests; the block grants one per cycle round-robin, supports bounded locked sequences, and rejects misaligned or out-of-range accesses. It drives the RAM's select, read, write, address and write-data inputs, and returns registered completions to the granted master.

## Interface
- ADDR_W, 32, request/RAM address width
- DATA_W, 32, data width (word = 4 bytes)
- MEM_BYTES, 1024, RAM size in bytes
- LOCK_MAX, 16, max consecutive granted cycles under lock before forced release
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mN_req  in  1  request valid (N = 0,1)
- mN_we  in  1  1 = write, 0 = read
- mN_lock  in  1  hold ownership after this access
- mN_addr  in  ADDR_W  byte address
- mN_wdata  in  DATA_W  write data
- mN_gnt  out  1  request accepted this cycle (combinational)
- mN_rvalid  out  1  completion, one cycle after grant
- mN_rdata  out  DATA_W  read data (0 for writes and errors)
- mN_err  out  1  completion is an error; valid with rvalid
- ram_sel  out  1  RAM select (HSEL)
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_addr  out  ADDR_W  RAM byte address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM combinational read data

## Operation
- Registered state: fsm {IDLE, OWN0, OWN1}; last_gnt (1 bit); lock_cnt (clog2(LOCK_MAX+1) bits); per-port rvalid/rdata/err registers.
- IDLE: one requester -> granted; both -> the port != last_gnt. Grant updates last_gnt.
- OWNx: only port x may be granted; other port's gnt held 0.
- Transitions: IDLE -> OWNx when port x granted with mx_lock=1 (lock_cnt <= 1). In OWNx, granted with lock=1 -> stay, lock_cnt++. OWNx -> IDLE when mx_req=0, or granted with lock=0, or a lock=1 grant makes lock_cnt reach LOCK_MAX (forced release; last_gnt = x, so the other port wins the next contention).
- Address check: error if addr[1:0] != 0 or addr > MEM_BYTES-4. Erroring access is still granted and counted for round-robin/lock, but ram_sel/ram_read/ram_write stay 0.
- RAM drive (same cycle as grant, valid access only): ram_sel=1, ram_read=!we, ram_write=we, ram_addr=addr, ram_wdata=wdata. No grant -> all strobes 0, addr/wdata 0.
- Completion: next cycle mN_rvalid=1 for exactly one cycle; mN_rdata = captured ram_rdata for valid reads, else 0; mN_err = address-check result.
- Never both gnt high; never ram_read and ram_write together.

## Timing
- Reset: all gnt 0, ram_* 0, rvalid 0, rdata 0, err 0, fsm IDLE, last_gnt=1 (port 0 wins first contention), lock_cnt 0.
- Grant and RAM strobes combinational from req and current state; write commits at the grant cycle's rising edge.
- Read latency: grant at cycle T, rvalid/rdata at T+1. Throughput 1 access/cycle, back-to-back allowed.
- Read in cycle after a write to same address returns new data.
- Requester holds req/addr/we/wdata until gnt; may drop req without penalty.
- Reset asserted mid-operation: pending completions discarded (rvalid 0 next cycle), lock released, fsm IDLE; the write at the edge where reset is sampled is not forwarded (gnt forced 0 during reset).

## Test plan
- Port 0 write 0xDEADBEEF to 0x010, then read 0x010 -> gnt each cycle, rvalid next cycle, read rdata 0xDEADBEEF, err 0.
- Both ports request reads continuously after reset -> grants alternate 0,1,0,1...; each rvalid one cycle after its grant.
- Port 1 locked sequence of 4 writes while port 0 requests -> port 0 gnt 0 throughout; port 0 granted the cycle after port 1 issues lock=0.
- Port 0 holds lock=1 with req continuous, port 1 requesting -> forced release after 16 grants; 17th cycle grants port 1.
- Port 1 reads 0x3FE (misaligned) and 0x400 (out of range) -> gnt 1, ram_sel 0, rvalid with err 1, rdata 0; 0x3FC read succeeds.
- Reset asserted the cycle after a granted read -> rvalid stays 0, fsm IDLE, next contention grants port 0.
